serial_addsub: RTL

- Parametrised, multi-cycle add/subtract unit built from a single DIGIT-bit full-adder slice plus a registered carry.
- Processes operands LSB-first, DIGIT bits per cycle, using a start/busy/done handshake.
- Serves as the area-lean successor to the single-bit combinational full adder in the arithmetic datapath library.
- Adds a subtract mode, signed-overflow detection and held results.

---
 rtl/arith_pkg.sv | 28 ++
 rtl/fa_slice.sv | 29 ++
 rtl/serial_addsub.sv | 139 +++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared types and elaboration helpers for the serial arithmetic units.
// Holds the FSM state encoding, counter sizing and the parameter legality check.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Legal when DIGIT is non-zero, divides WIDTH, and WIDTH is at least 2.
    function automatic bit digit_ok(input int unsigned width, input int unsigned digit);
        return (digit != 0) && (width >= 2) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/fa_slice.sv
// Combinational DIGIT-bit ripple-carry adder slice.
// Also exports the carry into its top bit so the caller can detect signed overflow.
module fa_slice #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract unit: one DIGIT-bit adder slice reused LSB-first over WIDTH/DIGIT cycles.
// Results, carry-out and signed overflow are held until the next operation completes.
module serial_addsub
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CW   = clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (!digit_ok(WIDTH, DIGIT)) begin : g_param_check
            $error("serial_addsub: DIGIT must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nx;
    logic             carry;
    logic             sub_q;
    logic             accept;
    logic             last;

    logic [DIGIT-1:0] d_b;
    logic [DIGIT-1:0] d_s;
    logic             d_cout;
    logic             d_cmsb;

    // Subtraction is a + ~b + ~cin, so the operand is inverted per digit here.
    assign d_b = b_sh[DIGIT-1:0] ^ {DIGIT{sub_q}};

    fa_slice #(
        .DIGIT(DIGIT)
    ) u_slice (
        .a    (a_sh[DIGIT-1:0]),
        .b    (d_b),
        .cin  (carry),
        .s    (d_s),
        .cout (d_cout),
        .c_msb(d_cmsb)
    );

    // New digit enters at the MSB end so the last digit lands the word in place.
    assign acc_nx = (acc >> DIGIT) | (WIDTH'(d_s) << (WIDTH - DIGIT));

    // Next-state and accept decode.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = (cnt == LAST);
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                accept   = start;
                state_nx = start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Operand shifting, carry chaining and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            cnt      <= '0;
            carry    <= 1'b0;
            sub_q    <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
        end else begin
            busy <= (state_nx == RUN);
            done <= (state_nx == DONE);
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                sub_q <= sub;
                carry <= sub ^ cin;
                cnt   <= '0;
                acc   <= '0;
            end else if (state == RUN) begin
                a_sh  <= a_sh >> DIGIT;
                b_sh  <= b_sh >> DIGIT;
                acc   <= acc_nx;
                carry <= d_cout;
                cnt   <= cnt + CW'(1);
                if (last) begin
                    sum      <= acc_nx;
                    cout     <= d_cout;
                    overflow <= d_cmsb ^ d_cout;
                end
            end
        end
    end

endmodule
